// File: rtl/core_pkg.sv
// Core-wide shared definitions used by the branch reservation station.
// Contents: data/tag widths, branch opcode encodings, the station entry
// payload struct and a helper that spots source-less branches (B, BL).
package core_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned LOG2_PREGS = 6;
   localparam int unsigned BRS_ROB_W  = 6;
   localparam int unsigned BRS_OP_W   = 12;

   localparam logic [5:0] OP_B     = 6'b100000;
   localparam logic [5:0] OP_BL    = 6'b100001;
   localparam logic [5:0] OP_CBZ   = 6'b100010;
   localparam logic [5:0] OP_CBNZ  = 6'b100011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FUNC_RET = 6'b111000;

   typedef struct packed {
      logic                  valid;
      logic [BRS_OP_W-1:0]   op;
      logic [LOG2_PREGS-1:0] dst_tag;
      logic [LOG2_PREGS-1:0] src1_tag;
      logic                  src1_rdy;
      logic [XLEN-1:0]       src1_val;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       imm;
      logic [BRS_ROB_W-1:0]  rob_tag;
   } brs_entry_t;

   // Unconditional branches carry no register source.
   function automatic logic brs_no_src(input logic [5:0] opcode);
      return (opcode == OP_B) || (opcode == OP_BL);
   endfunction

endpackage

// File: rtl/branch_rs_age_matrix_sel.sv
// Age-matrix oldest-ready selector.
// Ports: clk, reset (async, active-high); alloc (one-hot entry written this
// edge), free (entries released this edge), valid (current valid vector),
// ready (valid && operand ready); grant (one-hot oldest ready, combinational
// from registered matrix and the ready vector).
// Row i bit j set means entry i is older than entry j.
module age_matrix_sel #(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] free,
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] ready,
   output logic [DEPTH-1:0] grant
);

   logic [DEPTH-1:0] age [DEPTH];
   logic [DEPTH-1:0] blocked;

   // New entry is younger than every surviving entry and older than none.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (alloc[i])
                  age[i][j] <= 1'b0;
               else if (alloc[j])
                  age[i][j] <= valid[i] & ~free[i];
               else if (free[i] | free[j])
                  age[i][j] <= 1'b0;
            end
         end
      end
   end

   // An entry wins when no other ready entry is older than it.
   always_comb begin
      blocked = '0;
      grant   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            blocked[i] = blocked[i] | (ready[j] & age[j][i]);
         end
      end
      for (int i = 0; i < DEPTH; i++) grant[i] = ready[i] & ~blocked[i];
   end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branch ops until src1 is
// available, wakes entries from the CDB and issues the oldest ready entry
// each cycle to the branch execute unit (which never stalls).
// Ports: clk, reset (async, active-high); disp_* dispatch request/payload,
// disp_ready (free entry exists); cdb_* result broadcast; flush (sync kill of
// all entries); issue_* issued entry, all zero when issue_valid=0.
// Optional build macro BRS_OCC_EN adds the registered occupancy output.
module branch_rs #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned XLEN   = core_pkg::XLEN,
   parameter int unsigned PHYS_W = core_pkg::LOG2_PREGS,
   parameter int unsigned ROB_W  = 6,
   parameter int unsigned OP_W   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_valid,
   output logic              disp_ready,
   input  logic [OP_W-1:0]   disp_op,
   input  logic [PHYS_W-1:0] disp_dst_tag,
   input  logic [PHYS_W-1:0] disp_src1_tag,
   input  logic              disp_src1_rdy,
   input  logic [XLEN-1:0]   disp_src1_val,
   input  logic [XLEN-1:0]   disp_pc,
   input  logic [XLEN-1:0]   disp_imm,
   input  logic [ROB_W-1:0]  disp_rob_tag,
   input  logic              cdb_valid,
   input  logic [PHYS_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]   cdb_value,
   input  logic              flush,
   output logic              issue_valid,
   output logic [OP_W-1:0]   issue_op,
   output logic [PHYS_W-1:0] issue_dst_tag,
   output logic [XLEN-1:0]   issue_src1_val,
   output logic [XLEN-1:0]   issue_pc,
   output logic [XLEN-1:0]   issue_imm,
   output logic [ROB_W-1:0]  issue_rob_tag
`ifdef BRS_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   localparam int unsigned E_XLEN = core_pkg::XLEN;
   localparam int unsigned E_PHYS = core_pkg::LOG2_PREGS;
   localparam int unsigned E_ROB  = core_pkg::BRS_ROB_W;
   localparam int unsigned E_OP   = core_pkg::BRS_OP_W;

   core_pkg::brs_entry_t ent [DEPTH];
   core_pkg::brs_entry_t new_ent;

   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] alloc;
   logic [DEPTH-1:0] free;
   logic [DEPTH-1:0] grant;
   logic             full;
   logic             accept;
   logic             found;
   logic             disp_hit;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = ent[i].valid;
         ready_vec[i] = ent[i].valid & ent[i].src1_rdy;
      end
   end

`ifdef BRS_OCC_EN
   localparam int unsigned OCC_W = $clog2(DEPTH+1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else
         occupancy <= occupancy + OCC_W'(accept) - OCC_W'(|grant);
   end

   assign full = (occupancy == OCC_W'(DEPTH));
`else
   assign full = &valid_vec;
`endif

   // Readiness uses registered state only; an issue this cycle does not open a slot.
   assign disp_ready = ~full;
   assign accept     = disp_valid & ~full & ~flush;
   assign free       = flush ? valid_vec : grant;

   // Lowest-index free entry receives the dispatch.
   always_comb begin
      alloc = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_vec[i] && !found) begin
            alloc[i] = accept;
            found    = 1'b1;
         end
      end
   end

   // Dispatch payload, including source-less forcing and same-cycle CDB capture.
   assign disp_hit = cdb_valid && (cdb_tag == disp_src1_tag);

   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.op       = E_OP'(disp_op);
      new_ent.dst_tag  = E_PHYS'(disp_dst_tag);
      new_ent.src1_tag = E_PHYS'(disp_src1_tag);
      new_ent.pc       = E_XLEN'(disp_pc);
      new_ent.imm      = E_XLEN'(disp_imm);
      new_ent.rob_tag  = E_ROB'(disp_rob_tag);
      new_ent.src1_val = E_XLEN'(disp_src1_val);
      new_ent.src1_rdy = disp_src1_rdy |
                         core_pkg::brs_no_src(disp_op[OP_W-1 -: 6]);
      if (!new_ent.src1_rdy && disp_hit) begin
         new_ent.src1_rdy = 1'b1;
         new_ent.src1_val = E_XLEN'(cdb_value);
      end
   end

   // Entry storage: allocate, free on issue, CDB wakeup.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc[i]) begin
               ent[i] <= new_ent;
            end else begin
               if (grant[i]) ent[i].valid <= 1'b0;
               if (ent[i].valid && !ent[i].src1_rdy && cdb_valid &&
                   (PHYS_W'(ent[i].src1_tag) == cdb_tag)) begin
                  ent[i].src1_rdy <= 1'b1;
                  ent[i].src1_val <= E_XLEN'(cdb_value);
               end
            end
         end
      end
   end

   age_matrix_sel #(.DEPTH(DEPTH)) u_sel (
      .clk   (clk),
      .reset (reset),
      .alloc (alloc),
      .free  (free),
      .valid (valid_vec),
      .ready (ready_vec),
      .grant (grant)
   );

   // Issue mux; grant is one-hot so at most one entry drives the outputs.
   always_comb begin
      issue_valid    = |grant;
      issue_op       = '0;
      issue_dst_tag  = '0;
      issue_src1_val = '0;
      issue_pc       = '0;
      issue_imm      = '0;
      issue_rob_tag  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            issue_op       = OP_W'(ent[i].op);
            issue_dst_tag  = PHYS_W'(ent[i].dst_tag);
            issue_src1_val = XLEN'(ent[i].src1_val);
            issue_pc       = XLEN'(ent[i].pc);
            issue_imm      = XLEN'(ent[i].imm);
            issue_rob_tag  = ROB_W'(ent[i].rob_tag);
         end
      end
   end

endmodule

// File: tb/tb_branch_rs.sv
// Directed self-checking bench for branch_rs.
module tb_branch_rs;

   localparam logic [11:0] OPB    = 12'b100000_000000;
   localparam logic [11:0] OPCBZ  = 12'b100010_000000;
   localparam logic [11:0] OPCBNZ = 12'b100011_000000;
   localparam logic [11:0] OPRET  = 12'b000000_111000;

   logic        clk, reset;
   logic        disp_valid, disp_ready;
   logic [11:0] disp_op;
   logic [5:0]  disp_dst_tag, disp_src1_tag, disp_rob_tag;
   logic        disp_src1_rdy;
   logic [31:0] disp_src1_val, disp_pc, disp_imm;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        flush;
   logic        issue_valid;
   logic [11:0] issue_op;
   logic [5:0]  issue_dst_tag, issue_rob_tag;
   logic [31:0] issue_src1_val, issue_pc, issue_imm;
`ifdef BRS_OCC_EN
   logic [2:0]  occupancy;
`endif

   int checks = 0;
   int errors = 0;

   branch_rs dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_dst_tag(disp_dst_tag), .disp_src1_tag(disp_src1_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src1_val(disp_src1_val),
      .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_tag(disp_rob_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .flush(flush),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_dst_tag(issue_dst_tag), .issue_src1_val(issue_src1_val),
      .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rob_tag(issue_rob_tag)
`ifdef BRS_OCC_EN
      , .occupancy(occupancy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [11:0] op, input logic [5:0] tag,
                           input logic rdy, input logic [31:0] val,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [5:0] rob, input logic [5:0] dst);
      disp_op = op; disp_src1_tag = tag; disp_src1_rdy = rdy;
      disp_src1_val = val; disp_pc = pc; disp_imm = imm;
      disp_rob_tag = rob; disp_dst_tag = dst;
   endtask

   task automatic test_reset;
      reset = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
      cdb_tag = '0; cdb_value = '0;
      set_disp('0, '0, 1'b0, '0, '0, '0, '0, '0);
      tick; tick;
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", disp_ready); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got %0b exp 0", issue_valid); end
      checks++; if ({issue_op, issue_dst_tag, issue_src1_val, issue_pc, issue_imm, issue_rob_tag} !== '0) begin
         errors++; $display("FAIL rst_issue_data got pc=%h rob=%0d exp 0", issue_pc, issue_rob_tag); end
      reset = 1'b0;
      tick;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %0b exp 0", issue_valid); end
   endtask

   task automatic test_branch;
      set_disp(OPB, 6'd0, 1'b0, 32'h0, 32'h100, 32'h20, 6'd3, 6'd5);
      disp_valid = 1'b1;
      tick;
      disp_valid = 1'b0;
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL b_valid got %0b exp 1", issue_valid); end
      checks++; if (issue_pc !== 32'h100) begin errors++; $display("FAIL b_pc got %h exp 100", issue_pc); end
      checks++; if (issue_imm !== 32'h20) begin errors++; $display("FAIL b_imm got %h exp 20", issue_imm); end
      checks++; if (issue_rob_tag !== 6'd3) begin errors++; $display("FAIL b_rob got %0d exp 3", issue_rob_tag); end
      checks++; if (issue_dst_tag !== 6'd5) begin errors++; $display("FAIL b_dst got %0d exp 5", issue_dst_tag); end
      checks++; if (issue_op !== OPB) begin errors++; $display("FAIL b_op got %h exp %h", issue_op, OPB); end
      tick;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b_once got %0b exp 0", issue_valid); end
      checks++; if (issue_pc !== 32'h0) begin errors++; $display("FAIL b_idle_pc got %h exp 0", issue_pc); end
   endtask

   task automatic test_wakeup;
      set_disp(OPCBZ, 6'd7, 1'b0, 32'hdead, 32'h200, 32'h8, 6'd4, 6'd0);
      disp_valid = 1'b1;
      tick;
      disp_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cbz_wait got %0b exp 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd8; cdb_value = 32'h55;
      tick;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cbz_wrong_tag got %0b exp 0", issue_valid); end
      cdb_tag = 6'd7; cdb_value = 32'h0;
      #1;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cbz_no_comb got %0b exp 0", issue_valid); end
      tick;
      cdb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL cbz_wake got %0b exp 1", issue_valid); end
      checks++; if (issue_src1_val !== 32'h0) begin errors++; $display("FAIL cbz_val got %h exp 0", issue_src1_val); end
      checks++; if (issue_rob_tag !== 6'd4) begin errors++; $display("FAIL cbz_rob got %0d exp 4", issue_rob_tag); end
      tick;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cbz_once got %0b exp 0", issue_valid); end
   endtask

   task automatic test_same_cycle_wakeup;
      set_disp(OPCBNZ, 6'd9, 1'b0, 32'h77, 32'h300, 32'h4, 6'd5, 6'd0);
      disp_valid = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'h5;
      tick;
      disp_valid = 1'b0; cdb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL sc_valid got %0b exp 1", issue_valid); end
      checks++; if (issue_src1_val !== 32'h5) begin errors++; $display("FAIL sc_val got %h exp 5", issue_src1_val); end
      checks++; if (issue_rob_tag !== 6'd5) begin errors++; $display("FAIL sc_rob got %0d exp 5", issue_rob_tag); end
      tick;
   endtask

   task automatic test_age_order;
      logic [5:0] robs [4];
      logic [5:0] tags [4];
      logic       rdy_exp [4];
      robs = '{6'd1, 6'd2, 6'd3, 6'd4};
      tags = '{6'd20, 6'd21, 6'd20, 6'd22};
      rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         set_disp(OPCBZ, tags[i], 1'b0, 32'h0, 32'h400 + 32'(i), 32'h0, robs[i], 6'd0);
         disp_valid = 1'b1;
         tick;
         checks++; if (disp_ready !== rdy_exp[i]) begin errors++; $display("FAIL fill_ready[%0d] got %0b exp %0b", i, disp_ready, rdy_exp[i]); end
      end
      // Pending dispatch held while full; must not enter until a slot is free.
      set_disp(OPCBZ, 6'd30, 1'b0, 32'h0, 32'h500, 32'h0, 6'd9, 6'd0);
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_idle got %0b exp 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_value = 32'h1;
      tick;
      cdb_valid = 1'b0;
      checks++; if (issue_rob_tag !== 6'd1 || issue_valid !== 1'b1) begin errors++; $display("FAIL age_first got v=%0b rob=%0d exp rob 1", issue_valid, issue_rob_tag); end
      checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_issue_ready got %0b exp 0", disp_ready); end
      tick;
      checks++; if (issue_rob_tag !== 6'd3 || issue_valid !== 1'b1) begin errors++; $display("FAIL age_second got v=%0b rob=%0d exp rob 3", issue_valid, issue_rob_tag); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL freed_ready got %0b exp 1", disp_ready); end
      tick;
      disp_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL age_rest got %0b exp 0", issue_valid); end
      cdb_valid = 1'b1; cdb_tag = 6'd30; cdb_value = 32'h9;
      tick;
      cdb_valid = 1'b0;
      checks++; if (issue_rob_tag !== 6'd9 || issue_src1_val !== 32'h9) begin errors++; $display("FAIL late_disp got rob=%0d val=%h exp rob 9 val 9", issue_rob_tag, issue_src1_val); end
   endtask

   task automatic test_flush;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got v=%0b r=%0b exp 0 1", issue_valid, disp_ready); end
      set_disp(OPCBZ, 6'd40, 1'b0, 32'h0, 32'h600, 32'h0, 6'd5, 6'd0);
      disp_valid = 1'b1; tick;
      set_disp(OPCBZ, 6'd41, 1'b0, 32'h0, 32'h604, 32'h0, 6'd6, 6'd0);
      tick;
      set_disp(OPB, 6'd0, 1'b0, 32'h0, 32'h608, 32'h10, 6'd8, 6'd0);
      tick;
      checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd8) begin errors++; $display("FAIL pre_flush got v=%0b rob=%0d exp 1 8", issue_valid, issue_rob_tag); end
      flush = 1'b1;
      set_disp(OPB, 6'd0, 1'b0, 32'h0, 32'h700, 32'h0, 6'd15, 6'd0);
      cdb_valid = 1'b1; cdb_tag = 6'd40; cdb_value = 32'h3;
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd8) begin errors++; $display("FAIL flush_cycle got v=%0b rob=%0d exp 1 8", issue_valid, issue_rob_tag); end
      tick;
      flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", issue_valid); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", disp_ready); end
      cdb_valid = 1'b1; cdb_tag = 6'd41;
      tick;
      cdb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_dead got v=%0b rob=%0d exp 0", issue_valid, issue_rob_tag); end
   endtask

   task automatic test_back_to_back;
      logic [11:0] ops [3];
      logic [5:0]  robs [3];
      logic [31:0] vals [3];
      ops  = '{OPB, OPB, OPRET};
      robs = '{6'd10, 6'd11, 6'd12};
      vals = '{32'h0, 32'h0, 32'h400};
      disp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_disp(ops[i], 6'd30, 1'b1, 32'h400, 32'h800 + 32'(4*i), 32'h0, robs[i], 6'd0);
         tick;
         checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== robs[i]) begin errors++; $display("FAIL b2b_rob[%0d] got v=%0b rob=%0d exp %0d", i, issue_valid, issue_rob_tag, robs[i]); end
         if (i == 2) begin
            checks++; if (issue_src1_val !== vals[i] || issue_op !== OPRET) begin errors++; $display("FAIL ret_val got val=%h op=%h exp 400 %h", issue_src1_val, issue_op, OPRET); end
         end
      end
      disp_valid = 1'b0;
      tick;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", issue_valid); end
   endtask

   task automatic test_reset_mid;
      disp_valid = 1'b1;
      set_disp(OPCBZ, 6'd50, 1'b0, 32'h0, 32'h900, 32'h0, 6'd21, 6'd0); tick;
      set_disp(OPCBZ, 6'd51, 1'b0, 32'h0, 32'h904, 32'h0, 6'd22, 6'd0); tick;
      set_disp(OPB, 6'd0, 1'b0, 32'h0, 32'h908, 32'h0, 6'd20, 6'd0); tick;
      disp_valid = 1'b0;
      checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd20) begin errors++; $display("FAIL mid_issue got v=%0b rob=%0d exp 1 20", issue_valid, issue_rob_tag); end
      #2 reset = 1'b1;
      #1;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %0b exp 0", issue_valid); end
      checks++; if (disp_ready !== 1'b1 || issue_rob_tag !== 6'd0) begin errors++; $display("FAIL async_rst_state got r=%0b rob=%0d exp 1 0", disp_ready, issue_rob_tag); end
      tick;
      reset = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 6'd50; cdb_value = 32'h1;
      tick;
      cdb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_cleared got %0b exp 0", issue_valid); end
   endtask

   initial begin
      test_reset;
      test_branch;
      test_wakeup;
      test_same_cycle_wakeup;
      test_age_order;
      test_flush;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
